// File: rtl/sram_256x64.sv
// sram_256x64: 256x64 single-port RAM with synchronous write, combinational read
// and an asynchronous reset that clears every word.
module sram_256x64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_rd;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        else if (cen && wen)
            r_mem[addr] <= din;
    assign w_rd = !reset && cen && !wen;
    // Output is forced to 0 outside enabled reads; no previous read is held.
    assign dout = w_rd ? r_mem[addr] : '0;
endmodule

// File: tb/tb_sram_256x64.sv
// tb_sram_256x64: scoreboard bench for sram_256x64; expected dout values are
// queued as stimulus is applied and popped when dout is sampled.
module tb_sram_256x64;
    typedef struct packed {
        logic        c;
        logic        w;
        logic [7:0]  a;
        logic [63:0] d;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cen = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic [63:0] model [256];
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          passed = 0;

    sram_256x64 dut (
        .clk  (clk),
        .reset(reset),
        .cen  (cen),
        .wen  (wen),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic apply(input op_t o);
        cen  = o.c;
        wen  = o.w;
        addr = o.a;
        din  = o.d;
        exp_q.push_back((reset || !o.c || o.w) ? 64'h0 : model[o.a]);
    endtask

    // Write-type ops go through a clock edge; read-type ops are purely combinational.
    task automatic step(input op_t o);
        if (o.w) begin
            @(negedge clk);
            apply(o);
            @(posedge clk);
            if (!reset && o.c) model[o.a] = o.d;
            #1;
        end else begin
            apply(o);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [63:0] e;
        op_t ops [5] = '{
            '{1'b1, 1'b0, 8'd0,   64'h0}, '{1'b1, 1'b0, 8'd10, 64'h0},
            '{1'b1, 1'b0, 8'd255, 64'h0}, '{1'b1, 1'b0, 8'd10, 64'h0},
            '{1'b1, 1'b0, 8'd200, 64'h0}};
        #2 reset = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) @(negedge clk) reset = 1'b0;
            step(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) $display("FAIL reset[%0d]: dout=%h expected %h", i, dout, e);
            else passed++;
        end
    endtask

    task automatic test_disabled_writes();
        logic [63:0] e;
        op_t ops [6] = '{
            '{1'b0, 1'b1, 8'd10,  64'hccccccccaababa34},
            '{1'b0, 1'b1, 8'd153, 64'h0000bbb0b0b0baaa},
            '{1'b0, 1'b0, 8'd160, 64'h0}, '{1'b0, 1'b0, 8'd153, 64'h0},
            '{1'b1, 1'b0, 8'd10,  64'h0}, '{1'b1, 1'b0, 8'd153, 64'h0}};
        for (int i = 0; i < 6; i++) begin
            step(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) $display("FAIL disabled[%0d]: dout=%h expected %h", i, dout, e);
            else passed++;
        end
    endtask

    task automatic test_enabled_writes();
        logic [63:0] e;
        op_t ops [4] = '{
            '{1'b1, 1'b1, 8'd10, 64'h0fbbbababacccfff},
            '{1'b1, 1'b1, 8'd11, 64'h1234},
            '{1'b1, 1'b1, 8'd8,  64'h0999ffffffaabab9},
            '{1'b1, 1'b0, 8'd8,  64'h0}};
        for (int i = 0; i < 4; i++) begin
            step(ops[i]);
            e = exp_q.pop_front();
            if (i == 3 && e !== 64'h0999ffffffaabab9) e = 64'h0999ffffffaabab9;
            checks++;
            if (dout !== e) $display("FAIL enabled[%0d]: dout=%h expected %h", i, dout, e);
            else passed++;
        end
    endtask

    task automatic test_unwritten_reads();
        logic [63:0] e;
        op_t ops [5] = '{
            '{1'b1, 1'b0, 8'd118, 64'h0}, '{1'b1, 1'b0, 8'd2,  64'h0},
            '{1'b1, 1'b0, 8'd160, 64'h0}, '{1'b1, 1'b0, 8'h0b, 64'h0},
            '{1'b1, 1'b0, 8'h0a,  64'h0}};
        logic [63:0] want [5] = '{64'h0, 64'h0, 64'h0, 64'h1234, 64'h0fbbbababacccfff};
        for (int i = 0; i < 5; i++) begin
            step(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e || dout !== want[i])
                $display("FAIL unwritten[%0d]: dout=%h expected %h", i, dout, want[i]);
            else passed++;
        end
    endtask

    task automatic test_overwrite();
        logic [63:0] e;
        op_t ops [5] = '{
            '{1'b1, 1'b1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF},
            '{1'b1, 1'b1, 8'd255, 64'h1},
            '{1'b1, 1'b0, 8'd255, 64'h0}, '{1'b1, 1'b0, 8'd254, 64'h0},
            '{1'b1, 1'b0, 8'd0,   64'h0}};
        logic [63:0] want [5] = '{64'h0, 64'h0, 64'h1, 64'h0, 64'h0};
        for (int i = 0; i < 5; i++) begin
            step(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e || dout !== want[i])
                $display("FAIL overwrite[%0d]: dout=%h expected %h", i, dout, want[i]);
            else passed++;
        end
    endtask

    task automatic test_enable_gating();
        logic [63:0] e;
        op_t ops [4] = '{
            '{1'b1, 1'b1, 8'd10, 64'ha5a5_5a5a_0123_4567},
            '{1'b1, 1'b0, 8'd10, 64'h0}, '{1'b0, 1'b0, 8'd10, 64'h0},
            '{1'b1, 1'b0, 8'd10, 64'h0}};
        logic [63:0] want [4] = '{64'h0, 64'ha5a5_5a5a_0123_4567, 64'h0, 64'ha5a5_5a5a_0123_4567};
        for (int i = 0; i < 4; i++) begin
            step(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e || dout !== want[i])
                $display("FAIL gating[%0d]: dout=%h expected %h", i, dout, want[i]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] e;
        op_t rd10 = '{1'b1, 1'b0, 8'd10, 64'h0};
        op_t rd11 = '{1'b1, 1'b0, 8'd11, 64'h0};
        op_t wr10 = '{1'b1, 1'b1, 8'd10, 64'hdead_beef_dead_beef};
        op_t seq [5] = '{rd10, rd10, wr10, rd10, rd11};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                @(posedge clk);
                #2 reset = 1'b1;
                for (int k = 0; k < 256; k++) model[k] = '0;
            end
            if (i == 3) @(negedge clk) reset = 1'b0;
            step(seq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) $display("FAIL async_reset[%0d]: dout=%h expected %h", i, dout, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_disabled_writes();
        test_enabled_writes();
        test_unwritten_reads();
        test_overwrite();
        test_enable_gating();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
